// File: rtl/bridge_ctrl_if.sv
// Device-side request/response bus between the memory-stage bridge and its
// targets (data memory and the two timers).
interface bridge_ctrl_if;
  logic        dev_req;
  logic        dev_we;
  logic [1:0]  dev_sel;
  logic [31:0] dev_addr;
  logic [3:0]  dev_be;
  logic [31:0] dev_wdata;
  logic        dev_ack;
  logic [31:0] dev_rdata;

  modport master (
    output dev_req, dev_we, dev_sel, dev_addr, dev_be, dev_wdata,
    input  dev_ack, dev_rdata
  );

  modport slave (
    input  dev_req, dev_we, dev_sel, dev_addr, dev_be, dev_wdata,
    output dev_ack, dev_rdata
  );
endinterface

// File: rtl/bridge_ctrl.sv
// Memory-stage bridge: decodes the access, stalls the pipeline while the
// selected device responds, and reports address and bus errors.
module bridge_ctrl #(
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req,
  input  logic               we,
  input  logic [31:0]        addr,
  input  logic [3:0]         be,
  input  logic [31:0]        wdata,
  input  logic               ade_in,
  output logic               stall,
  output logic [31:0]        rdata,
  output logic [1:0]         exc,
  bridge_ctrl_if.master      bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [3:0] TMO = 4'(TIMEOUT);

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  cnt;
  logic        hit_dm;
  logic        hit_t0;
  logic        hit_t1;
  logic        bad_map;
  logic [1:0]  sel_dec;
  logic        accept;
  logic        acc_ade;
  logic        acc_bus;
  logic        acc_ok;
  logic        tmo_hit;

  // Address decode and accept classification
  always_comb begin
    hit_dm  = (addr <= 32'h0000_2FFF);
    hit_t0  = (addr >= 32'h0000_7F00) && (addr <= 32'h0000_7F0B);
    hit_t1  = (addr >= 32'h0000_7F10) && (addr <= 32'h0000_7F1B);
    if (hit_t0) begin
      sel_dec = 2'b01;
    end else if (hit_t1) begin
      sel_dec = 2'b10;
    end else begin
      sel_dec = 2'b00;
    end
    // Timers only support full-word accesses
    bad_map = !(hit_dm || hit_t0 || hit_t1) || ((hit_t0 || hit_t1) && (be != 4'b1111));
    accept  = req && ((state == IDLE) || (state == DONE));
    acc_ade = accept && ade_in;
    acc_bus = accept && !ade_in && bad_map;
    acc_ok  = accept && !ade_in && !bad_map;
    tmo_hit = (state == ISSUE) && !bus.dev_ack && (cnt == TMO);
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (acc_ok) begin
          state_nxt = ISSUE;
        end else begin
          state_nxt = IDLE;
        end
      end
      ISSUE: begin
        if (bus.dev_ack) begin
          state_nxt = DONE;
        end else if (tmo_hit) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = ISSUE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Pipeline and device handshake outputs
  always_comb begin
    stall       = 1'b0;
    exc         = 2'b00;
    bus.dev_req = 1'b0;
    if (!reset) begin
      stall       = 1'b0;
      exc         = 2'b00;
      bus.dev_req = 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          stall = acc_ok;
          if (acc_ade) begin
            exc = 2'b01;
          end else if (acc_bus) begin
            exc = 2'b10;
          end else begin
            exc = 2'b00;
          end
        end
        ISSUE: begin
          bus.dev_req = !tmo_hit;
          stall       = !tmo_hit;
          exc         = tmo_hit ? 2'b10 : 2'b00;
        end
        default: begin
          stall       = 1'b0;
          exc         = 2'b00;
          bus.dev_req = 1'b0;
        end
      endcase
    end
  end

  // Wait counter for the device response
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= 4'd0;
    end else if (acc_ok) begin
      cnt <= 4'd0;
    end else if ((state == ISSUE) && !bus.dev_ack && !tmo_hit) begin
      cnt <= cnt + 4'd1;
    end else begin
      cnt <= cnt;
    end
  end

  // Request bundle captured on accept and held through ISSUE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.dev_sel   <= 2'b00;
      bus.dev_we    <= 1'b0;
      bus.dev_addr  <= 32'h0000_0000;
      bus.dev_be    <= 4'b0000;
      bus.dev_wdata <= 32'h0000_0000;
    end else if (acc_ok) begin
      bus.dev_sel   <= sel_dec;
      bus.dev_we    <= we;
      bus.dev_addr  <= addr;
      bus.dev_be    <= be;
      bus.dev_wdata <= wdata;
    end
  end

  // Load data capture; stores leave the previous value
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata <= 32'h0000_0000;
    end else if ((state == ISSUE) && bus.dev_ack && !bus.dev_we) begin
      rdata <= bus.dev_rdata;
    end
  end

endmodule

// File: tb/tb_bridge_ctrl.sv
// Directed self-checking bench for bridge_ctrl; device responses are driven by hand.
module tb_bridge_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        ade_in;
  logic        stall;
  logic [31:0] rdata;
  logic [1:0]  exc;
  int          checks = 0;
  int          errors = 0;

  bridge_ctrl_if bus_if ();

  bridge_ctrl #(.TIMEOUT(15)) dut (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .we     (we),
    .addr   (addr),
    .be     (be),
    .wdata  (wdata),
    .ade_in (ade_in),
    .stall  (stall),
    .rdata  (rdata),
    .exc    (exc),
    .bus    (bus_if)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic w, input logic [31:0] a,
                       input logic [3:0] b, input logic [31:0] d, input logic ae);
    req = r; we = w; addr = a; be = b; wdata = d; ade_in = ae;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (stall !== 1'b0 || exc !== 2'b00 || bus_if.dev_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got stall=%b exc=%b dev_req=%b, want 0/00/0", stall, exc, bus_if.dev_req);
    end
    checks++;
    if (rdata !== 32'h0 || bus_if.dev_addr !== 32'h0 || bus_if.dev_sel !== 2'b00 || bus_if.dev_we !== 1'b0) begin
      errors++;
      $display("FAIL reset_data: got rdata=%h dev_addr=%h dev_sel=%b dev_we=%b, want zeros", rdata, bus_if.dev_addr, bus_if.dev_sel, bus_if.dev_we);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_load();
    int stall_cycles = 0;
    step();
    drive(1'b1, 1'b0, 32'h0000_0010, 4'b1111, 32'h0, 1'b0);
    @(negedge clk);
    if (stall === 1'b1) stall_cycles++;
    checks++;
    if (stall !== 1'b1 || exc !== 2'b00 || bus_if.dev_req !== 1'b0) begin
      errors++;
      $display("FAIL load_accept: got stall=%b exc=%b dev_req=%b, want 1/00/0", stall, exc, bus_if.dev_req);
    end
    step();
    bus_if.dev_ack = 1'b1; bus_if.dev_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    if (stall === 1'b1) stall_cycles++;
    checks++;
    if (bus_if.dev_req !== 1'b1 || bus_if.dev_sel !== 2'b00 || bus_if.dev_addr !== 32'h10 || exc !== 2'b00) begin
      errors++;
      $display("FAIL load_issue: got dev_req=%b sel=%b addr=%h exc=%b, want 1/00/00000010/00", bus_if.dev_req, bus_if.dev_sel, bus_if.dev_addr, exc);
    end
    step();
    bus_if.dev_ack = 1'b0; req = 1'b0;
    @(negedge clk);
    if (stall === 1'b1) stall_cycles++;
    checks++;
    if (rdata !== 32'hDEAD_BEEF || exc !== 2'b00 || bus_if.dev_req !== 1'b0) begin
      errors++;
      $display("FAIL load_done: got rdata=%h exc=%b dev_req=%b, want deadbeef/00/0", rdata, exc, bus_if.dev_req);
    end
    checks++;
    if (stall_cycles != 2) begin
      errors++;
      $display("FAIL load_stall_len: got %0d stall cycles, want 2", stall_cycles);
    end
  endtask

  task automatic test_store();
    step();
    drive(1'b1, 1'b1, 32'h0000_7F14, 4'b1111, 32'h0000_0009, 1'b0);
    @(negedge clk);
    checks++;
    if (stall !== 1'b1 || exc !== 2'b00) begin
      errors++;
      $display("FAIL store_accept: got stall=%b exc=%b, want 1/00", stall, exc);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      if (i == 2) bus_if.dev_ack = 1'b1;
      @(negedge clk);
      checks++;
      if (bus_if.dev_req !== 1'b1 || stall !== 1'b1 || bus_if.dev_sel !== 2'b10 ||
          bus_if.dev_we !== 1'b1 || bus_if.dev_wdata !== 32'h9 || bus_if.dev_be !== 4'b1111) begin
        errors++;
        $display("FAIL store_issue%0d: got req=%b stall=%b sel=%b we=%b wdata=%h be=%b, want 1/1/10/1/00000009/1111",
                 i, bus_if.dev_req, stall, bus_if.dev_sel, bus_if.dev_we, bus_if.dev_wdata, bus_if.dev_be);
      end
    end
    step();
    bus_if.dev_ack = 1'b0; req = 1'b0;
    @(negedge clk);
    checks++;
    if (stall !== 1'b0 || bus_if.dev_req !== 1'b0 || rdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL store_done: got stall=%b dev_req=%b rdata=%h, want 0/0/deadbeef", stall, bus_if.dev_req, rdata);
    end
  endtask

  task automatic test_errors();
    logic [31:0] a_tab [5] = '{32'h0000_7F04, 32'h0000_0003, 32'h0000_3000, 32'h0000_7F0C, 32'h0000_7F1C};
    logic [3:0]  b_tab [5] = '{4'b0001, 4'b1111, 4'b1111, 4'b1111, 4'b1111};
    logic        e_tab [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [1:0]  x_tab [5] = '{2'b10, 2'b01, 2'b10, 2'b10, 2'b10};
    for (int i = 0; i < 5; i++) begin
      step();
      drive(1'b1, 1'b1, a_tab[i], b_tab[i], 32'h5, e_tab[i]);
      @(negedge clk);
      checks++;
      if (exc !== x_tab[i] || stall !== 1'b0 || bus_if.dev_req !== 1'b0) begin
        errors++;
        $display("FAIL err_pulse%0d: got exc=%b stall=%b dev_req=%b, want %b/0/0", i, exc, stall, bus_if.dev_req, x_tab[i]);
      end
      step();
      req = 1'b0; ade_in = 1'b0;
      @(negedge clk);
      checks++;
      if (exc !== 2'b00 || bus_if.dev_req !== 1'b0) begin
        errors++;
        $display("FAIL err_after%0d: got exc=%b dev_req=%b, want 00/0", i, exc, bus_if.dev_req);
      end
    end
  endtask

  task automatic test_timeout();
    step();
    drive(1'b1, 1'b0, 32'h0000_0100, 4'b1111, 32'h0, 1'b0);
    for (int i = 0; i < 15; i++) begin
      step();
      @(negedge clk);
      checks++;
      if (bus_if.dev_req !== 1'b1 || stall !== 1'b1 || exc !== 2'b00) begin
        errors++;
        $display("FAIL tmo_wait%0d: got req=%b stall=%b exc=%b, want 1/1/00", i, bus_if.dev_req, stall, exc);
      end
    end
    step();
    req = 1'b0;
    @(negedge clk);
    checks++;
    if (exc !== 2'b10 || bus_if.dev_req !== 1'b0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL tmo_pulse: got exc=%b dev_req=%b stall=%b, want 10/0/0", exc, bus_if.dev_req, stall);
    end
    step();
    @(negedge clk);
    checks++;
    if (exc !== 2'b00 || bus_if.dev_req !== 1'b0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL tmo_idle: got exc=%b dev_req=%b stall=%b, want 00/0/0", exc, bus_if.dev_req, stall);
    end
  endtask

  task automatic test_back_to_back();
    step();
    drive(1'b1, 1'b0, 32'h0000_2FFC, 4'b1111, 32'h0, 1'b0);
    step();
    bus_if.dev_ack = 1'b1; bus_if.dev_rdata = 32'h1111_1111;
    step();
    bus_if.dev_ack = 1'b0;
    drive(1'b1, 1'b0, 32'h0000_0020, 4'b1111, 32'h0, 1'b0);
    @(negedge clk);
    checks++;
    if (rdata !== 32'h1111_1111 || stall !== 1'b1 || exc !== 2'b00 || bus_if.dev_req !== 1'b0) begin
      errors++;
      $display("FAIL b2b_done: got rdata=%h stall=%b exc=%b dev_req=%b, want 11111111/1/00/0", rdata, stall, exc, bus_if.dev_req);
    end
    step();
    bus_if.dev_ack = 1'b1; bus_if.dev_rdata = 32'h2222_2222;
    @(negedge clk);
    checks++;
    if (bus_if.dev_req !== 1'b1 || bus_if.dev_addr !== 32'h20) begin
      errors++;
      $display("FAIL b2b_issue: got dev_req=%b dev_addr=%h, want 1/00000020", bus_if.dev_req, bus_if.dev_addr);
    end
    step();
    bus_if.dev_ack = 1'b0; req = 1'b0;
    @(negedge clk);
    checks++;
    if (rdata !== 32'h2222_2222 || stall !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second: got rdata=%h stall=%b, want 22222222/0", rdata, stall);
    end
    // Abort a pending access with reset while in ISSUE
    step();
    drive(1'b1, 1'b0, 32'h0000_0040, 4'b1111, 32'h0, 1'b0);
    step();
    @(negedge clk);
    checks++;
    if (bus_if.dev_req !== 1'b1) begin
      errors++;
      $display("FAIL abort_pre: got dev_req=%b, want 1", bus_if.dev_req);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (bus_if.dev_req !== 1'b0 || stall !== 1'b0 || exc !== 2'b00 || bus_if.dev_addr !== 32'h0 || rdata !== 32'h0) begin
      errors++;
      $display("FAIL abort_reset: got req=%b stall=%b exc=%b addr=%h rdata=%h, want 0/0/00/0/0",
               bus_if.dev_req, stall, exc, bus_if.dev_addr, rdata);
    end
    req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    step();
    @(negedge clk);
    checks++;
    if (bus_if.dev_req !== 1'b0 || stall !== 1'b0 || exc !== 2'b00) begin
      errors++;
      $display("FAIL abort_idle: got req=%b stall=%b exc=%b, want 0/0/00", bus_if.dev_req, stall, exc);
    end
  endtask

  initial begin
    reset = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 4'b0000, 32'h0, 1'b0);
    bus_if.dev_ack   = 1'b0;
    bus_if.dev_rdata = 32'h0;
    test_reset();
    test_load();
    test_store();
    test_errors();
    test_timeout();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
